// File: rtl/x_motor_step_ramp_gen.sv
// x_motor_step_ramp_gen
// Turns a host move command into a trapezoidal STEP/DIR pulse train for the
// X-axis stepper driver.
//
// The interval after step k, measured from one step rise to the next, is:
//   I_k = max(S_eff - d*min(k-1, N-1-k, r_max), Me)
// Every interval is clamped so that it is never shorter than 2*PULSE_W.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   accel_word     [31:16] r_max (ramp steps), [15:0] d (period delta, cycles)
//   target_steps   move length N in steps
//   start_period   first and last step interval S
//   min_period     cruise interval floor M
//   dir_in         requested direction, 1 = positive
//   go             a rising edge starts a move (only accepted while idle)
//   abort          stops a running move on the next cycle
//   pos_clear      synchronous clear of the position counter
//   step, dir      driver outputs
//   busy, done     move status; done is a one-cycle completion pulse
//   position       signed step count, wraps in two's complement
module x_motor_step_ramp_gen #(
  parameter int unsigned PULSE_W  = 50,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         accel_word,
  input  logic [31:0]         target_steps,
  input  logic [PERIOD_W-1:0] start_period,
  input  logic [PERIOD_W-1:0] min_period,
  input  logic                dir_in,
  input  logic                go,
  input  logic                abort,
  input  logic                pos_clear,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic [31:0]         position
);

  localparam int unsigned PROD_W = (PERIOD_W > 32) ? PERIOD_W : 32;
  localparam logic [PERIOD_W-1:0] MIN_IV  = PERIOD_W'(2 * PULSE_W);
  localparam logic [PERIOD_W-1:0] PW_LAST = PERIOD_W'(PULSE_W - 1);
  localparam logic [PERIOD_W-1:0] PW_END  = PERIOD_W'(PULSE_W);

  typedef enum logic [1:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL} state_e;

  state_e                state_q, state_d;
  logic                  step_q, step_d;
  logic                  dir_q, dir_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  go_q, go_d;
  logic [31:0]           pos_q, pos_d;
  logic [31:0]           n_q, n_d;
  logic [31:0]           k_q, k_d;
  logic [15:0]           r_max_q, r_max_d;
  logic [15:0]           delta_q, delta_d;
  logic [PERIOD_W-1:0]   s_eff_q, s_eff_d;
  logic [PERIOD_W-1:0]   me_q, me_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;

  // Interval for the current step k_q, derived from the latched profile.
  logic [31:0]         ramp_a, ramp_b, ramp_m32;
  logic [15:0]         ramp_m;
  logic [PROD_W-1:0]   ramp_prod;
  logic [PERIOD_W-1:0] ramp_diff, interval;

  always_comb begin
    ramp_a   = k_q - 32'd1;
    ramp_b   = n_q - k_q - 32'd1;
    ramp_m32 = (ramp_a < ramp_b) ? ramp_a : ramp_b;
    ramp_m   = (ramp_m32 > 32'(r_max_q)) ? r_max_q : ramp_m32[15:0];
    ramp_prod = PROD_W'(delta_q) * PROD_W'(ramp_m);
    // The subtraction saturates at zero instead of wrapping.
    if (ramp_prod >= PROD_W'(s_eff_q)) begin
      ramp_diff = '0;
    end else begin
      ramp_diff = PERIOD_W'(PROD_W'(s_eff_q) - ramp_prod);
    end
    interval = (ramp_diff > me_q) ? ramp_diff : me_q;
  end

  // Effective start period and floor, computed from the live inputs at go.
  logic [PERIOD_W-1:0] s_eff_in, m_floor_in, me_in;

  always_comb begin
    s_eff_in   = (start_period < MIN_IV) ? MIN_IV : start_period;
    m_floor_in = (min_period < MIN_IV) ? MIN_IV : min_period;
    me_in      = (m_floor_in < s_eff_in) ? m_floor_in : s_eff_in;
  end

  // Profile segment label for the step about to start (internal only).
  function automatic state_e label_for(input logic [31:0] kn, input logic [31:0] n,
                                       input logic [15:0] r);
    logic [31:0] a, b;
    a = kn - 32'd1;
    b = n - kn - 32'd1;
    if (kn >= n)                           label_for = S_DECEL;
    else if (a <= b && a <= 32'(r))        label_for = S_ACCEL;
    else if (b < a && b <= 32'(r))         label_for = S_DECEL;
    else                                   label_for = S_CRUISE;
  endfunction

  logic go_edge;
  logic rise;

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    go_d    = go;
    n_d     = n_q;
    k_d     = k_q;
    r_max_d = r_max_q;
    delta_d = delta_q;
    s_eff_d = s_eff_q;
    me_d    = me_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    go_edge = go & ~go_q;

    case (state_q)
      S_IDLE: begin
        if (go_edge && !abort) begin
          n_d     = target_steps;
          r_max_d = accel_word[31:16];
          delta_d = accel_word[15:0];
          s_eff_d = s_eff_in;
          me_d    = me_in;
          dir_d   = dir_in;
          if (target_steps == 32'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            step_d  = 1'b1;
            k_d     = 32'd1;
            cnt_d   = '0;
            state_d = S_ACCEL;
            rise    = 1'b1;
          end
        end
      end
      default: begin
        if (abort) begin
          state_d = S_IDLE;
          step_d  = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
          if (cnt_q == PW_LAST) step_d = 1'b0;
          if (k_q == n_q) begin
            // Last step: finish once its pulse has fallen.
            if (cnt_q == PW_END) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              step_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else if (cnt_q == interval - PERIOD_W'(1)) begin
            rise    = 1'b1;
            step_d  = 1'b1;
            cnt_d   = '0;
            k_d     = k_q + 32'd1;
            state_d = label_for(k_q + 32'd1, n_q, r_max_q);
          end
        end
      end
    endcase

    // Clear first, then count a coinciding step rise.
    pos_d = pos_clear ? 32'd0 : pos_q;
    if (rise) pos_d = dir_d ? (pos_d + 32'd1) : (pos_d - 32'd1);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      go_q    <= 1'b0;
      pos_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      r_max_q <= '0;
      delta_q <= '0;
      s_eff_q <= '0;
      me_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      go_q    <= go_d;
      pos_q   <= pos_d;
      n_q     <= n_d;
      k_q     <= k_d;
      r_max_q <= r_max_d;
      delta_q <= delta_d;
      s_eff_q <= s_eff_d;
      me_q    <= me_d;
      cnt_q   <= cnt_d;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign position = pos_q;

endmodule

// File: tb/tb_x_motor_step_ramp_gen.sv
// Directed bench for x_motor_step_ramp_gen with PULSE_W=2.
module tb_x_motor_step_ramp_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] accel_word;
  logic [31:0] target_steps;
  logic [15:0] start_period;
  logic [15:0] min_period;
  logic        dir_in, go, abort, pos_clear;
  logic        step, dir, busy, done;
  logic [31:0] position;

  x_motor_step_ramp_gen #(.PULSE_W(2), .PERIOD_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .accel_word(accel_word),
    .target_steps(target_steps), .start_period(start_period),
    .min_period(min_period), .dir_in(dir_in), .go(go), .abort(abort),
    .pos_clear(pos_clear), .step(step), .dir(dir), .busy(busy),
    .done(done), .position(position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation log: rise cycles, position at each rise, done pulses.
  int          rises[$];
  logic [31:0] rise_pos[$];
  int          done_cnt = 0;
  int          busy_seen = 0;
  logic        step_prev = 1'b0;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (step && !step_prev) begin
        rises.push_back(cyc);
        rise_pos.push_back(position);
      end
      if (done) done_cnt++;
      if (busy) busy_seen = 1;
    end
    step_prev = step;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int t_go;
  task automatic pulse_go(input logic [31:0] aw, input logic [31:0] n, input logic [15:0] s,
                          input logic [15:0] m, input logic d);
    accel_word   = aw;
    target_steps = n;
    start_period = s;
    min_period   = m;
    dir_in       = d;
    go           = 1'b1;
    t_go         = cyc;
    tick(1);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  int exp_iv[$];
  task automatic check_iv(input string tag);
    check({tag, "_rise_count"}, 64'(rises.size()), 64'(exp_iv.size() + 1));
    for (int i = 0; i < exp_iv.size(); i++) begin
      if (i + 1 < rises.size()) check(tag, 64'(rises[i+1] - rises[i]), 64'(exp_iv[i]));
    end
  endtask

  task automatic clear_pos();
    pos_clear = 1'b1;
    tick(1);
    pos_clear = 1'b0;
    check("pos_clear", 64'(position), 64'd0);
    rises.delete();
    rise_pos.delete();
  endtask

  int t_done;
  int done_base;

  initial begin
    reset_n = 1'b0; accel_word = '0; target_steps = '0; start_period = '0;
    min_period = '0; dir_in = 1'b0; go = 1'b0; abort = 1'b0; pos_clear = 1'b0;
    tick(3);
    check("rst_step", 64'(step), 64'd0);
    check("rst_dir", 64'(dir), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_position", 64'(position), 64'd0);
    reset_n = 1'b1;
    tick(2);

    // 1: N=10 full trapezoid
    rises.delete();
    pulse_go({16'd3, 16'd20}, 32'd10, 16'd100, 16'd40, 1'b1);
    check("t1_busy_start", 64'(busy), 64'd1);
    check("t1_dir", 64'(dir), 64'd1);
    wait_done(2000, t_done);
    check("t1_first_rise", 64'(rises[0]), 64'(t_go + 1));
    exp_iv = '{100, 80, 60, 40, 40, 40, 60, 80, 100};
    check_iv("t1_interval");
    check("t1_done_time", 64'(t_done), 64'(rises[rises.size()-1] + 3));
    check("t1_busy_at_done", 64'(busy), 64'd0);
    check("t1_position", 64'(position), 64'd10);
    tick(1);
    check("t1_done_pulse_width", 64'(done), 64'd0);

    // 2: N=4 truncated ramp
    clear_pos();
    pulse_go({16'd3, 16'd20}, 32'd4, 16'd100, 16'd40, 1'b1);
    wait_done(2000, t_done);
    exp_iv = '{100, 80, 100};
    check_iv("t2_interval");
    check("t2_position", 64'(position), 64'd4);

    // 3: N=0 completes immediately without stepping
    clear_pos();
    busy_seen = 0;
    pulse_go({16'd3, 16'd20}, 32'd0, 16'd100, 16'd40, 1'b1);
    check("t3_done_t1", 64'(done), 64'd1);
    tick(5);
    check("t3_busy_seen", 64'(busy_seen), 64'd0);
    check("t3_no_step", 64'(rises.size()), 64'd0);

    // 4: abort at the 5th step rise, then a new go two cycles later
    clear_pos();
    done_base = done_cnt;
    pulse_go({16'd3, 16'd20}, 32'd1000, 16'd100, 16'd40, 1'b1);
    for (int i = 0; i < 2000 && rises.size() < 5; i++) tick(1);
    check("t4_reached_5", 64'(rises.size()), 64'd5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t4_abort_step", 64'(step), 64'd0);
    check("t4_abort_busy", 64'(busy), 64'd0);
    check("t4_abort_pos", 64'(position), 64'd5);
    check("t4_abort_no_done", 64'(done_cnt - done_base), 64'd0);
    tick(1);
    pulse_go({16'd0, 16'd0}, 32'd2, 16'd100, 16'd40, 1'b1);
    check("t4_rego_busy", 64'(busy), 64'd1);
    wait_done(2000, t_done);
    check("t4_rego_rise", 64'(rises[5]), 64'(t_go + 1));
    check("t4_position", 64'(position), 64'd7);
    check("t4_done_count", 64'(done_cnt - done_base), 64'd1);

    // Abort coinciding with a go edge: the edge is ignored
    done_base = done_cnt;
    rises.delete();
    accel_word = '0; target_steps = 32'd3; start_period = 16'd10; min_period = 16'd10;
    abort = 1'b1;
    go = 1'b1;
    tick(1);
    check("t4b_busy", 64'(busy), 64'd0);
    tick(4);
    abort = 1'b0;
    tick(2);
    check("t4b_no_step", 64'(rises.size()), 64'd0);
    check("t4b_no_done", 64'(done_cnt - done_base), 64'd0);
    go = 1'b0;
    tick(2);

    // 5: negative direction, constant speed, clear on the third rise
    clear_pos();
    pulse_go({16'd3, 16'd0}, 32'd3, 16'd10, 16'd10, 1'b0);
    check("t5_dir", 64'(dir), 64'd0);
    tick(19);
    pos_clear = 1'b1;
    tick(1);
    pos_clear = 1'b0;
    check("t5_third_rise_step", 64'(step), 64'd1);
    check("t5_clear_and_count", 64'(position), 64'(32'hFFFF_FFFF));
    wait_done(200, t_done);
    exp_iv = '{10, 10};
    check_iv("t5_interval");
    check("t5_pos_rise2", 64'(rise_pos[1]), 64'(32'hFFFF_FFFE));
    check("t5_position", 64'(position), 64'(32'hFFFF_FFFF));

    // 6: clamp to 2*PULSE_W, re-edge mid-move ignored, go held high
    clear_pos();
    done_base = done_cnt;
    accel_word = {16'd3, 16'd5}; target_steps = 32'd4; start_period = 16'd3;
    min_period = 16'd1; dir_in = 1'b1;
    go = 1'b1;
    t_go = cyc;
    tick(3);
    go = 1'b0;
    tick(1);
    go = 1'b1;
    wait_done(200, t_done);
    tick(20);
    exp_iv = '{4, 4, 4};
    check_iv("t6_interval");
    check("t6_first_rise", 64'(rises[0]), 64'(t_go + 1));
    check("t6_done_count", 64'(done_cnt - done_base), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_position", 64'(position), 64'd4);
    go = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/x_motor_step_ramp_gen.md
Name: x_motor_step_ramp_gen

Overview:
- Downstream consumer of the X-axis accelstep PIO word.
- Turns an HPS-issued move command into a trapezoidal-profile STEP/DIR pulse train for the X stepper driver.
- Acceleration shape comes from the 32-bit accelstep word.
- Move length, start period, cruise period and direction come from sibling PIO outputs; busy/done/position feed back to HPS-readable input PIOs.

Parameters:
PULSE_W, 50, STEP high width in clk cycles (1..32767)
PERIOD_W, 16, width of all period fields in clk cycles

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
accel_word  in  32  [31:16] ramp_steps r_max, [15:0] period_delta d (cycles)
target_steps  in  32  move length N in steps
start_period  in  PERIOD_W  first/last step interval S
min_period  in  PERIOD_W  cruise interval floor M
dir_in  in  1  1 = positive direction
go  in  1  level; rising edge starts a move
abort  in  1  level; stops the move immediately
pos_clear  in  1  synchronous clear of position
step  out  1  step pulse to driver
dir  out  1  latched direction
busy  out  1  move in progress
done  out  1  one-cycle pulse at move completion
position  out  32  signed step count

Behaviour:
- Reset (async, reset_n=0): step=0, dir=0, busy=0, done=0, position=0, state=IDLE, go edge register=0. Takes effect mid-move immediately.
- Go edge: go=1 this cycle with go registered 0 last cycle. Ignored unless state=IDLE and abort=0.
- On an accepted edge at cycle T: latch accel_word, target_steps, start_period, min_period and dir_in. dir updates at T+1.
- If N=0: done=1 at T+1, busy stays 0, state stays IDLE.
- Otherwise at T+1: busy=1, step=1 (step 1), state=ACCEL.
- Effective floor Me = max(M, S_clamped, 2*PULSE_W)? No: S_eff = max(S, 2*PULSE_W) and Me = min(max(M, 2*PULSE_W), S_eff).
- Interval after step k (k=1..N-1), measured rising edge to rising edge:
  I_k = max(S_eff - d*min(k-1, N-1-k, r_max), Me).
  Subtraction saturates at 0 before the max; no wrap.
- State label: ACCEL while k-1 is the minimum term, DECEL while N-1-k is the minimum, CRUISE otherwise. Labels are internal only; output timing is defined solely by I_k.
- Each step is high for exactly PULSE_W cycles, then low for I_k - PULSE_W cycles.
- Position: +1 (dir=1) or -1 (dir=0) in the cycle step rises; wraps two's-complement.
- pos_clear: position=0 next cycle. If it coincides with a step rise, the result is ±1 (clear then count).
- Completion: step N falls at cycle E, then done=1 and busy=0 at E+1, state=IDLE. A go edge at E+1 is accepted.
- Abort in any non-IDLE state: next cycle step=0, busy=0, state=IDLE, done=0; position keeps steps already counted.
- Abort asserted in the same cycle as a go edge: the edge is ignored.
- Inputs changed mid-move are ignored until the next accepted go.
- d=0 or r_max=0: all intervals are S_eff (constant speed).
- Odd or short N: the ramp is truncated symmetrically by the min() term; peak speed may not reach Me.

Test Plan:
1. Reset, PULSE_W=2, S=100, M=40, accel_word={16'd3,16'd20}, N=10, dir_in=1, go edge -> rising-edge intervals 100,80,60,40,40,40,60,80,100; position=10; done single pulse 3 cycles after the last step rises (PULSE_W=2 high + 1); busy low on that same cycle.
2. N=4, same profile -> intervals 100,80,100 (ramp truncated); position=4.
3. N=0, go edge -> done=1 at T+1, busy never high, no step.
4. N=1000, S=100, M=40, abort asserted at the 5th step rise -> step=0 and busy=0 next cycle, no done, position=5; a new go edge 2 cycles later is accepted.
5. dir_in=0, N=3, d=0, S=10 (PULSE_W=2) -> intervals 10,10; position=-3. pos_clear asserted on the third step rise -> position=-1.
6. S=3, M=1, PULSE_W=2 -> all intervals 4 (2*PULSE_W clamp). Second go edge mid-move is ignored; go held high yields only one move.
